instr_fetch_queue: RTL and testbench

Fetch-side instruction queue that sits directly upstream of the dispatcher. It requests 128-bit lines (4 instructions) from the instruction cache and buffers up to DEPTH lines. It presents one instruction per cycle, together with its PC+4, to the dispatcher. On a dispatcher jump/branch redirect it flushes all buffered and in-flight state and refetches from the target address.

---
 rtl/instr_fetch_queue.sv | 120 ++++++++++++
 tb/tb_instr_fetch_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Fetch-side instruction queue: pulls 128-bit lines from the I-cache, buffers up to
// DEPTH lines and hands one instruction per cycle (with PC+4) to the dispatcher.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  output logic [31:0]  o_cache_addr,
  output logic         o_cache_rd_en,
  input  logic [127:0] i_cache_dout,
  input  logic         i_cache_dout_valid,
  input  logic         i_rd_en,
  input  logic [31:0]  i_jmp_br_addr,
  input  logic         i_jmp_valid,
  output logic [31:0]  o_instruction,
  output logic [31:0]  o_pc_plus_4,
  output logic         o_empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t         r_state;
  state_t         w_next;

  logic [127:0]   r_lines [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic [1:0]     r_offset;
  logic [27:0]    r_line_pc;   // fetch PC in line units
  logic [31:0]    r_pc_out;

  logic           w_req;
  logic           w_wr;
  logic           w_rd;
  logic           w_pop;
  logic           w_empty;

  assign w_empty = (r_count == '0);
  assign w_wr    = (r_state == S_WAIT) & i_cache_dout_valid & ~i_jmp_valid & ~i_rst;
  assign w_rd    = i_rd_en & ~w_empty & ~i_jmp_valid;
  assign w_pop   = w_rd & (r_offset == 2'd3);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_next = S_WAIT;
      S_WAIT: begin
        if (i_cache_dout_valid) w_next = S_IDLE;
        else if (i_jmp_valid)   w_next = S_DROP;
      end
      S_DROP: if (i_cache_dout_valid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic: request is masked during reset so no pulse escapes the reset cycle
  always_comb begin
    w_req = (r_state == S_IDLE) & (r_count < LP_DEPTH) & ~i_jmp_valid & ~i_rst;
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_lines[r_wr_ptr] <= i_cache_dout;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_offset  <= '0;
      r_line_pc <= RESET_PC[31:4];
      r_pc_out  <= RESET_PC;
    end else if (i_jmp_valid) begin
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_offset  <= i_jmp_br_addr[3:2];
      r_line_pc <= i_jmp_br_addr[31:4];
      r_pc_out  <= i_jmp_br_addr;
    end else begin
      if (w_wr) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_line_pc <= r_line_pc + 28'd1;
      end
      if (w_rd) begin
        r_pc_out <= r_pc_out + 32'd4;
        r_offset <= r_offset + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_cache_addr  = {r_line_pc, 4'b0000};
  assign o_cache_rd_en = w_req;
  assign o_instruction = r_lines[r_rd_ptr][{r_offset, 5'b00000} +: 32];
  assign o_pc_plus_4   = r_pc_out + 32'd4;
  assign o_empty       = w_empty;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a latency-programmable cache model returns
// lines whose words equal their own addresses, so expected instructions equal PCs.
module tb_instr_fetch_queue;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [31:0]  o_cache_addr;
  logic         o_cache_rd_en;
  logic [127:0] i_cache_dout;
  logic         i_cache_dout_valid;
  logic         i_rd_en;
  logic [31:0]  i_jmp_br_addr;
  logic         i_jmp_valid;
  logic [31:0]  o_instruction;
  logic [31:0]  o_pc_plus_4;
  logic         o_empty;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .o_cache_addr       (o_cache_addr),
    .o_cache_rd_en      (o_cache_rd_en),
    .i_cache_dout       (i_cache_dout),
    .i_cache_dout_valid (i_cache_dout_valid),
    .i_rd_en            (i_rd_en),
    .i_jmp_br_addr      (i_jmp_br_addr),
    .i_jmp_valid        (i_jmp_valid),
    .o_instruction      (o_instruction),
    .o_pc_plus_4        (o_pc_plus_4),
    .o_empty            (o_empty)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rd;
    logic        jmp;
    logic [31:0] addr;
    logic        empty;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        req;
    logic [31:0] caddr;
  } vec_t;

  vec_t        vecs [9];
  int          errors = 0;
  int          checks = 0;
  int          lat    = 1;
  int          pend   = 0;
  logic [31:0] pend_addr;
  logic        req_s;
  logic [31:0] addr_s;

  function automatic logic [127:0] mk_line(input logic [31:0] a);
    return {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction

  // One clock: sample the request at negedge, then advance the cache model.
  task automatic tick();
    @(negedge i_clk);
    req_s  = o_cache_rd_en;
    addr_s = o_cache_addr;
    @(posedge i_clk);
    #1;
    i_cache_dout_valid = 1'b0;
    if (req_s) begin
      pend      = lat;
      pend_addr = addr_s;
    end
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        i_cache_dout_valid = 1'b1;
        i_cache_dout       = mk_line(pend_addr);
      end
    end
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h108, 1'b1, 32'h0,   32'h10C, 1'b1, 32'h100};
    vecs[1] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   32'h10C, 1'b0, 32'h100};
    vecs[2] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h108, 32'h10C, 1'b1, 32'h110};
    vecs[3] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h10C, 32'h110, 1'b0, 32'h110};
    vecs[4] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h110, 32'h114, 1'b1, 32'h120};
    vecs[5] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h110, 32'h114, 1'b0, 32'h120};
    vecs[6] = '{1'b1, 1'b1, 32'h300, 1'b1, 32'h0,   32'h304, 1'b1, 32'h300};
    vecs[7] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h304, 1'b0, 32'h300};
    vecs[8] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h300, 32'h304, 1'b1, 32'h310};

    i_rst = 1'b1; i_rd_en = 1'b0; i_jmp_valid = 1'b0; i_jmp_br_addr = '0;
    i_cache_dout = '0; i_cache_dout_valid = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_req",   {31'b0, o_cache_rd_en}, 32'd0);
    chk("rst_empty", {31'b0, o_empty},       32'd1);
    chk("rst_pc4",   o_pc_plus_4,            32'h4);
    chk("rst_caddr", o_cache_addr,           32'h0);
    i_rst = 1'b0;
    #1;

    // Initial fill, one request outstanding at a time
    for (int i = 0; i < 4; i++) begin
      chk("fill_req",   {31'b0, o_cache_rd_en}, 32'd1);
      chk("fill_caddr", o_cache_addr,           32'(16 * i));
      tick();
      chk("fill_wait_req", {31'b0, o_cache_rd_en}, 32'd0);
      chk("fill_wait_empty", {31'b0, o_empty}, (i == 0) ? 32'd1 : 32'd0);
      tick();
    end
    chk("full_empty", {31'b0, o_empty}, 32'd0);
    chk("full_instr", o_instruction,    32'h0);
    chk("full_pc4",   o_pc_plus_4,      32'h4);
    for (int i = 0; i < 3; i++) begin
      chk("full_noreq", {31'b0, o_cache_rd_en}, 32'd0);
      tick();
    end

    // Spurious valid while IDLE and full must be ignored
    i_cache_dout_valid = 1'b1;
    i_cache_dout       = {4{32'hDEAD_BEEF}};
    tick();
    chk("spur_instr", o_instruction,            32'h0);
    chk("spur_req",   {31'b0, o_cache_rd_en},   32'd0);
    chk("spur_empty", {31'b0, o_empty},         32'd0);

    // Continuous dispatch
    i_rd_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      chk("strm_instr", o_instruction,    32'(4 * i));
      chk("strm_pc4",   o_pc_plus_4,      32'(4 * i + 4));
      chk("strm_empty", {31'b0, o_empty}, 32'd0);
      tick();
    end
    i_rd_en = 1'b0;
    repeat (12) tick();

    // Redirect table (latency 1), starting full and idle
    for (int v = 0; v < 9; v++) begin
      i_rd_en       = vecs[v].rd;
      i_jmp_valid   = vecs[v].jmp;
      i_jmp_br_addr = vecs[v].addr;
      tick();
      i_rd_en     = 1'b0;
      i_jmp_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d_empty", v), {31'b0, o_empty},       {31'b0, vecs[v].empty});
      chk($sformatf("vec%0d_pc4", v),   o_pc_plus_4,            vecs[v].pc4);
      chk($sformatf("vec%0d_req", v),   {31'b0, o_cache_rd_en}, {31'b0, vecs[v].req});
      chk($sformatf("vec%0d_caddr", v), o_cache_addr,           vecs[v].caddr);
      if (!vecs[v].empty)
        chk($sformatf("vec%0d_instr", v), o_instruction, vecs[v].instr);
    end

    // Redirect during WAIT (latency 3) -> DROP, then re-redirect inside DROP
    lat = 3;
    tick();
    chk("drop_wait_req", {31'b0, o_cache_rd_en}, 32'd0);
    i_jmp_valid = 1'b1; i_jmp_br_addr = 32'h200;
    tick();
    i_jmp_valid = 1'b0;
    #1;
    chk("drop_empty", {31'b0, o_empty},       32'd1);
    chk("drop_req",   {31'b0, o_cache_rd_en}, 32'd0);
    chk("drop_caddr", o_cache_addr,           32'h200);
    chk("drop_pc4",   o_pc_plus_4,            32'h204);
    i_jmp_valid = 1'b1; i_jmp_br_addr = 32'h244;
    tick();
    i_jmp_valid = 1'b0;
    #1;
    chk("drop2_req",   {31'b0, o_cache_rd_en}, 32'd0);
    chk("drop2_caddr", o_cache_addr,           32'h240);
    chk("drop2_pc4",   o_pc_plus_4,            32'h248);
    tick();
    chk("drop_done_empty", {31'b0, o_empty},       32'd1);
    chk("drop_done_req",   {31'b0, o_cache_rd_en}, 32'd1);
    chk("drop_done_caddr", o_cache_addr,           32'h240);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("refetch_empty", {31'b0, o_empty}, 32'd1);
    end
    tick();
    chk("refetch_empty2", {31'b0, o_empty}, 32'd0);
    chk("refetch_instr",  o_instruction,    32'h244);
    chk("refetch_pc4",    o_pc_plus_4,      32'h248);
    i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
    #1;
    chk("refetch_rd_instr", o_instruction,            32'h248);
    chk("refetch_rd_pc4",   o_pc_plus_4,              32'h24C);
    chk("refetch_rd_req",   {31'b0, o_cache_rd_en},   32'd0);

    // Reset while WAIT; the late line lands under reset and is ignored
    i_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wrst_empty", {31'b0, o_empty},       32'd1);
      chk("wrst_req",   {31'b0, o_cache_rd_en}, 32'd0);
      chk("wrst_caddr", o_cache_addr,           32'h0);
      chk("wrst_pc4",   o_pc_plus_4,            32'h4);
    end
    i_rst = 1'b0;
    lat   = 1;
    #1;
    chk("post_rst_req",   {31'b0, o_cache_rd_en}, 32'd1);
    chk("post_rst_empty", {31'b0, o_empty},       32'd1);
    tick();
    tick();
    chk("post_rst_empty2", {31'b0, o_empty}, 32'd0);
    chk("post_rst_instr",  o_instruction,    32'h0);
    chk("post_rst_pc4",    o_pc_plus_4,      32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
